// File: rtl/cpu_pkg.sv
// Shared encodings and types for the single-cycle MIPS subset core:
// opcode/funct codes, ALU operation and hex-select enums, counter type.
`timescale 1ns/1ps
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    HEX_PC      = 3'd0,
    HEX_INSTR   = 3'd1,
    HEX_ALU     = 3'd2,
    HEX_GPR2    = 3'd3,
    HEX_GPR16   = 3'd4,
    HEX_NEXT_PC = 3'd5,
    HEX_CNT_CLK = 3'd6,
    HEX_ZERO    = 3'd7
  } hex_sel_e;

  typedef logic [10:0] cnt_t;
endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two asynchronous read ports, one clocked write port,
// $0 hardwired to zero; $2 and $16 are tapped for the debug display.
`timescale 1ns/1ps
module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] gpr2,
  output logic [31:0] gpr16
);
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
  assign gpr2    = regs[2];
  assign gpr16   = regs[16];
endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS subset core with instruction ROM, data RAM and retire counters.
// Optional CPU_HALT_EN: syscall retires once, then freezes the core until reset.
`timescale 1ns/1ps
module single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter string IMEM_FILE  = "program.hex",
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        expesrc0,
  input  logic        expsrc1,
  input  logic        expsrc2,
  output logic [10:0] cnt_i,
  output logic [10:0] cnt_r,
  output logic [10:0] cnt_j,
  output logic [10:0] cnt_clk,
  output logic [31:0] hex
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0] pc_reg, pc_next, pc_plus4, branch_target, instr;
  logic [31:0] rs_data, rt_data, gpr2, gpr16, imm_ext, alu_b, alu_result;
  logic [31:0] load_data, wdata;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, waddr;
  logic [15:0] imm;
  logic [25:0] tgt;
  cnt_t        cnt_i_reg, cnt_r_reg, cnt_j_reg, cnt_clk_reg;
  alu_op_e     alu_op;
  logic        use_imm, zext, reg_we, mem_rd, mem_we, br_eq, br_ne, jump, jump_reg, link;
  logic        halted, halt_req;

  assign instr    = imem[pc_reg[IW+1:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign tgt      = instr[25:0];
  assign pc_plus4 = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    alu_op = ALU_ADD; use_imm = 1'b0; zext = 1'b0; reg_we = 1'b0; waddr = rd;
    mem_rd = 1'b0; mem_we = 1'b0; br_eq = 1'b0; br_ne = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; link = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_JR:           begin reg_we = 1'b0; jump_reg = 1'b1; end
          FN_SYSCALL:      reg_we = 1'b0;
          default:         reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_XORI: begin alu_op = ALU_XOR; use_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; waddr = rt; end
      OP_LW:   begin use_imm = 1'b1; mem_rd = 1'b1; reg_we = 1'b1; waddr = rt; end
      OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
      OP_BEQ:  br_eq = 1'b1;
      OP_BNE:  br_ne = 1'b1;
      OP_J:    jump = 1'b1;
      OP_JAL:  begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; waddr = 5'd31; end
      default: ;
    endcase
  end

  assign imm_ext = zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = use_imm ? imm_ext : rt_data;

  // Shifts take rt as the operand and shamt as the distance.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = rs_data + alu_b;
      ALU_SUB:  alu_result = rs_data - alu_b;
      ALU_AND:  alu_result = rs_data & alu_b;
      ALU_OR:   alu_result = rs_data | alu_b;
      ALU_XOR:  alu_result = rs_data ^ alu_b;
      ALU_NOR:  alu_result = ~(rs_data | alu_b);
      ALU_SLT:  alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, rs_data < alu_b};
      ALU_SLL:  alu_result = rt_data << shamt;
      ALU_SRL:  alu_result = rt_data >> shamt;
      ALU_SRA:  alu_result = $signed(rt_data) >>> shamt;
      ALU_LUI:  alu_result = {imm, 16'd0};
      default:  alu_result = '0;
    endcase
  end

  assign load_data = dmem[alu_result[DW+1:2]];
  assign wdata     = link ? pc_plus4 : (mem_rd ? load_data : alu_result);

  always_ff @(posedge clk) begin
    if (!reset && !halted && mem_we) dmem[alu_result[DW+1:2]] <= rt_data;
  end

  cpu_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_we && !halted),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .gpr2    (gpr2),
    .gpr16   (gpr16)
  );

`ifdef CPU_HALT_EN
  logic halted_reg;
  assign halt_req = !halted_reg && (op == OP_RTYPE) && (funct == FN_SYSCALL);
  always_ff @(posedge clk) begin
    if (reset)         halted_reg <= 1'b0;
    else if (halt_req) halted_reg <= 1'b1;
  end
  assign halted = halted_reg;
`else
  assign halt_req = 1'b0;
  assign halted   = 1'b0;
`endif

  // A halting syscall keeps PC on itself so the display shows where it stopped.
  always_comb begin
    pc_next = pc_plus4;
    if (jump_reg)  pc_next = rs_data;
    else if (jump) pc_next = {pc_plus4[31:28], tgt, 2'b00};
    else if ((br_eq && rs_data == rt_data) || (br_ne && rs_data != rt_data))
      pc_next = branch_target;
    if (halt_req) pc_next = pc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= '0;
      cnt_i_reg   <= '0;
      cnt_r_reg   <= '0;
      cnt_j_reg   <= '0;
      cnt_clk_reg <= '0;
    end else if (!halted) begin
      pc_reg      <= pc_next;
      cnt_clk_reg <= cnt_clk_reg + 11'd1;
      if (op == OP_RTYPE)                  cnt_r_reg <= cnt_r_reg + 11'd1;
      else if (op == OP_J || op == OP_JAL) cnt_j_reg <= cnt_j_reg + 11'd1;
      else                                 cnt_i_reg <= cnt_i_reg + 11'd1;
    end
  end

  assign cnt_i   = cnt_i_reg;
  assign cnt_r   = cnt_r_reg;
  assign cnt_j   = cnt_j_reg;
  assign cnt_clk = cnt_clk_reg;

  always_comb begin
    hex = '0;
    case (hex_sel_e'({expsrc2, expsrc1, expesrc0}))
      HEX_PC:      hex = pc_reg;
      HEX_INSTR:   hex = instr;
      HEX_ALU:     hex = alu_result;
      HEX_GPR2:    hex = gpr2;
      HEX_GPR16:   hex = gpr16;
      HEX_NEXT_PC: hex = pc_next;
      HEX_CNT_CLK: hex = {21'd0, cnt_clk_reg};
      HEX_ZERO:    hex = 32'h0;
      default:     hex = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: loads a program into the ROM, then checks
// counters and debug-display words at fixed cycles with hand-computed values.
`timescale 1ns/1ps
module tb_single_cycle_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        expesrc0 = 1'b0, expsrc1 = 1'b0, expsrc2 = 1'b0;
  logic [10:0] cnt_i, cnt_r, cnt_j, cnt_clk;
  logic [31:0] hex;
  int          n_vec = 0;
  int          n_err = 0;

  single_cycle_cpu #(.IMEM_FILE(""), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .expesrc0(expesrc0), .expsrc1(expsrc1), .expsrc2(expsrc2),
    .cnt_i(cnt_i), .cnt_r(cnt_r), .cnt_j(cnt_j), .cnt_clk(cnt_clk), .hex(hex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hchk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    {expsrc2, expsrc1, expesrc0} = sel;
    #0.1;
    chk(tag, hex, exp);
  endtask

  task automatic cnt_chk(input string tag, input int ei, input int er, input int ej, input int ec);
    chk({tag, "_cnt_i"},   {21'd0, cnt_i},   ei);
    chk({tag, "_cnt_r"},   {21'd0, cnt_r},   er);
    chk({tag, "_cnt_j"},   {21'd0, cnt_j},   ej);
    chk({tag, "_cnt_clk"}, {21'd0, cnt_clk}, ec);
  endtask

  logic [31:0] alu_exp [16] = '{
    32'h80000000, 32'hF8000000, 32'h00F80000, 32'h00F8FFFF,
    32'h00F87FFE, 32'h000070F0, 32'h00070F00, 32'h00070F00,
    32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF3,
    32'h0000000D, 32'h00000001, 32'h0000000D, 32'h0000000C
  };

  initial begin
    for (int k = 0; k < 256; k++) dut.imem[k] = 32'h0;
    dut.imem[0]  = i_ins(6'h08, 5'd0, 5'd2, 16'd5);       // addi $2,$0,5
    dut.imem[1]  = i_ins(6'h08, 5'd0, 5'd3, 16'd7);       // addi $3,$0,7
    dut.imem[2]  = r_ins(5'd2, 5'd3, 5'd2, 5'd0, 6'h20);  // add $2,$2,$3
    dut.imem[3]  = i_ins(6'h2B, 5'd0, 5'd2, 16'd4);       // sw $2,4($0)
    dut.imem[4]  = i_ins(6'h23, 5'd0, 5'd16, 16'd4);      // lw $16,4($0)
    dut.imem[5]  = i_ins(6'h08, 5'd0, 5'd2, 16'd10);      // addi $2,$0,10
    dut.imem[6]  = i_ins(6'h08, 5'd2, 5'd2, 16'hFFFF);    // addi $2,$2,-1
    dut.imem[7]  = i_ins(6'h05, 5'd2, 5'd0, 16'hFFFE);    // bne $2,$0,-2
    dut.imem[8]  = i_ins(6'h04, 5'd0, 5'd0, 16'd1);       // beq $0,$0,+1
    dut.imem[9]  = i_ins(6'h08, 5'd0, 5'd2, 16'h55);      // skipped
    dut.imem[10] = i_ins(6'h04, 5'd2, 5'd3, 16'd1);       // beq $2,$3 (not taken)
    dut.imem[11] = j_ins(6'h03, 26'h20);                  // jal 0x80
    dut.imem[12] = i_ins(6'h0F, 5'd0, 5'd2, 16'h8000);    // lui
    dut.imem[13] = r_ins(5'd0, 5'd2, 5'd2, 5'd4, 6'h03);  // sra 4
    dut.imem[14] = r_ins(5'd0, 5'd2, 5'd2, 5'd8, 6'h02);  // srl 8
    dut.imem[15] = i_ins(6'h0D, 5'd2, 5'd2, 16'hFFFF);    // ori
    dut.imem[16] = i_ins(6'h0E, 5'd2, 5'd2, 16'h8001);    // xori
    dut.imem[17] = i_ins(6'h0C, 5'd2, 5'd2, 16'hF0F0);    // andi
    dut.imem[18] = r_ins(5'd0, 5'd2, 5'd2, 5'd4, 6'h00);  // sll 4
    dut.imem[19] = i_ins(6'h08, 5'd0, 5'd3, 16'hFFFF);    // addi $3,$0,-1
    dut.imem[20] = r_ins(5'd3, 5'd2, 5'd2, 5'd0, 6'h2A);  // slt
    dut.imem[21] = r_ins(5'd3, 5'd2, 5'd2, 5'd0, 6'h2B);  // sltu
    dut.imem[22] = r_ins(5'd2, 5'd0, 5'd2, 5'd0, 6'h27);  // nor
    dut.imem[23] = r_ins(5'd2, 5'd16, 5'd2, 5'd0, 6'h26); // xor
    dut.imem[24] = r_ins(5'd0, 5'd2, 5'd2, 5'd0, 6'h22);  // sub
    dut.imem[25] = i_ins(6'h0A, 5'd2, 5'd2, 16'd14);      // slti
    dut.imem[26] = r_ins(5'd2, 5'd16, 5'd2, 5'd0, 6'h25); // or
    dut.imem[27] = r_ins(5'd2, 5'd16, 5'd2, 5'd0, 6'h24); // and
    dut.imem[28] = i_ins(6'h08, 5'd0, 5'd0, 16'd9);       // addi $0,$0,9
    dut.imem[29] = r_ins(5'd0, 5'd0, 5'd16, 5'd0, 6'h20); // add $16,$0,$0
    dut.imem[30] = 32'h0000000C;                          // syscall
    dut.imem[31] = j_ins(6'h02, 26'h1F);                  // j 0x7C
    dut.imem[32] = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08); // jr $31

    step(2);
    reset = 1'b0;
    cnt_chk("reset", 0, 0, 0, 0);
    hchk("reset_pc",    3'd0, 32'h0);
    hchk("reset_instr", 3'd1, 32'h20020005);
    hchk("reset_alu",   3'd2, 32'h5);
    hchk("reset_gpr2",  3'd3, 32'h0);
    hchk("reset_npc",   3'd5, 32'h4);
    hchk("reset_zero",  3'd7, 32'h0);

    step(1);
    cnt_chk("first", 1, 0, 0, 1);
    hchk("first_pc", 3'd0, 32'h4);
    step(2);
    hchk("add_gpr2", 3'd3, 32'hC);
    cnt_chk("add", 2, 1, 0, 3);
    step(2);
    hchk("lw_gpr16", 3'd4, 32'hC);
    step(3);
    hchk("loop1_pc", 3'd0, 32'h18);
    hchk("loop1_gpr2", 3'd3, 32'h9);
    cnt_chk("loop1", 7, 1, 0, 8);
    step(18);
    hchk("loopend_pc", 3'd0, 32'h20);
    hchk("loopend_gpr2", 3'd3, 32'h0);
    chk("loopend_cnt_i", {21'd0, cnt_i}, 25);
    step(1);
    hchk("beq_taken_pc", 3'd0, 32'h28);
    step(1);
    hchk("beq_not_taken_pc", 3'd0, 32'h2C);
    step(1);
    hchk("jal_pc", 3'd0, 32'h80);
    hchk("jr_target", 3'd5, 32'h30);
    step(1);
    hchk("jr_pc", 3'd0, 32'h30);
    cnt_chk("jr", 27, 2, 1, 30);
    for (int k = 0; k < 16; k++) begin
      step(1);
      hchk($sformatf("alu_step%0d", k), 3'd3, alu_exp[k]);
    end
    cnt_chk("alu", 33, 12, 1, 46);
    step(2);
    hchk("r0_write_gpr16", 3'd4, 32'h0);
    step(1);
`ifdef CPU_HALT_EN
    step(100);
    hchk("halt_pc", 3'd0, 32'h78);
    cnt_chk("halt", 34, 14, 1, 49);
`else
    step(1);
    hchk("syscall_nop_pc", 3'd0, 32'h7C);
    cnt_chk("syscall_nop", 34, 14, 2, 50);
`endif

    // Mid-run reset with the store removed: the load must still see the old data.
    reset = 1'b1;
    dut.imem[3] = 32'h0;
    step(2);
    reset = 1'b0;
    cnt_chk("rerun_reset", 0, 0, 0, 0);
    hchk("rerun_pc", 3'd0, 32'h0);
    step(5);
    hchk("dmem_kept", 3'd4, 32'hC);
    cnt_chk("rerun", 3, 2, 0, 5);
`ifdef CPU_HALT_EN
    step(144);
    hchk("rehalt_pc", 3'd0, 32'h78);
    cnt_chk("rehalt", 33, 15, 1, 49);
`else
    step(2095);
    hchk("wrap_clk_hex", 3'd6, 32'd52);
    hchk("wrap_pc", 3'd0, 32'h7C);
    cnt_chk("wrap", 33, 15, 4, 52);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
